// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: owns SR/Cause/EPC/PRId and turns M-stage
// error, interrupt and eret events into one-cycle flush/redirect pulses.
module cp0_exc_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        StallM,
  input  logic        ErrorM,
  input  logic [4:0]  ExcCodeM,
  input  logic        BDM,
  input  logic [31:0] PCM,
  input  logic        EretM,
  input  logic        CP0WeM,
  input  logic [4:0]  CP0AddrM,
  input  logic [31:0] CP0WdM,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0RdM,
  output logic        Nullify,
  output logic        InterruptRequest,
  output logic        RedirectValid,
  output logic [31:0] RedirectPC,
  output logic [31:0] EPCOut
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REDIRECT
  } state_t;

  state_t state, next_state;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic int_pend;
  logic act;
  logic exc_ok;
  logic take_int;
  logic take_exc;
  logic take;
  logic do_eret;
  logic do_wr;

  assign int_pend = (|(HWInt & im)) & ie & ~exl;
  assign exc_ok   = ErrorM & ~exl;
  assign EPCOut   = epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!StallM) begin
          if (int_pend && !ValidM)  next_state = WAIT;
          else if (take || do_eret) next_state = REDIRECT;
        end
      end
      WAIT: begin
        if (!StallM) begin
          if (!int_pend)   next_state = IDLE;
          else if (ValidM) next_state = REDIRECT;
        end
      end
      REDIRECT: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Event decode; only IDLE/WAIT with M unfrozen may fire anything.
  always_comb begin
    act      = (state == IDLE) && !StallM && ValidM;
    take_int = (act && int_pend) ||
               ((state == WAIT) && !StallM &&
                ValidM && int_pend);
    take_exc = act && !int_pend && exc_ok;
    take     = take_int || take_exc;
    do_eret  = act && !int_pend && !exc_ok && EretM;
    do_wr    = act && !int_pend && !exc_ok &&
               !EretM && CP0WeM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Nullify          <= 1'b0;
      InterruptRequest <= 1'b0;
      RedirectValid    <= 1'b0;
      RedirectPC       <= 32'h0;
    end else begin
      Nullify          <= take || do_eret;
      RedirectValid    <= take || do_eret;
      InterruptRequest <= take_int;
      if (take)         RedirectPC <= HANDLER_ADDR;
      else if (do_eret) RedirectPC <= epc;
      else              RedirectPC <= 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= 6'h0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'h0;
      exc_code <= 5'h0;
      epc      <= 32'h0;
    end else begin
      ip <= HWInt;
      if (take) begin
        exl      <= 1'b1;
        bd       <= BDM;
        epc      <= BDM ? PCM - 32'd4 : PCM;
        exc_code <= take_int ? 5'd0 : ExcCodeM;
      end else if (do_eret) begin
        exl <= 1'b0;
      end else if (do_wr) begin
        if (CP0AddrM == 5'd12) begin
          im  <= CP0WdM[15:10];
          exl <= CP0WdM[1];
          ie  <= CP0WdM[0];
        end
        if (CP0AddrM == 5'd14)
          epc <= CP0WdM & ~32'h3;
      end
    end
  end

  always_comb begin
    CP0RdM = 32'h0;
    case (CP0AddrM)
      5'd12:   CP0RdM = {16'h0, im, 8'h0, exl, ie};
      5'd13:   CP0RdM = {bd, 15'h0, ip, 3'h0,
                         exc_code, 2'h0};
      5'd14:   CP0RdM = epc;
      5'd15:   CP0RdM = PRID_VAL;
      default: CP0RdM = 32'h0;
    endcase
  end

endmodule
